// File: rtl/imem_loader_if.sv
// Loader port bundle: the host-side byte stream with its control/status, plus
// the instruction-memory byte write port driven by the loader.
interface imem_loader_if #(
    parameter int ADDR_W = 8
);
    logic              ld_start;
    logic [ADDR_W:0]   ld_len;
    logic              ld_abort;
    logic              ld_valid;
    logic [7:0]        ld_data;
    logic              ld_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [7:0]        mem_wdata;
    logic              core_rst;
    logic              busy;
    logic              done;
    logic              err;
    logic [7:0]        ld_sum;

    modport master (
        output ld_start, ld_len, ld_abort, ld_valid, ld_data,
        input  ld_ready, mem_we, mem_waddr, mem_wdata, core_rst, busy, done, err, ld_sum
    );

    modport slave (
        input  ld_start, ld_len, ld_abort, ld_valid, ld_data,
        output ld_ready, mem_we, mem_waddr, mem_wdata, core_rst, busy, done, err, ld_sum
    );
endinterface

// File: rtl/imem_loader.sv
// Streams a program into the byte-wide instruction memory while holding the
// core in reset, then releases the core after a fixed hold period.
module imem_loader #(
    parameter int MEM_BYTES   = 256,
    parameter int ADDR_W      = 8,
    parameter int HOLD_CYCLES = 4
) (
    input logic         clk,
    input logic         rst,
    imem_loader_if.slave bus
);
    localparam int                HOLD_W      = $clog2(HOLD_CYCLES) + 1;
    localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [ADDR_W:0]   MAX_LEN     = (ADDR_W + 1)'(MEM_BYTES);

    typedef enum logic [1:0] {
        S_HOLD,
        S_RUN,
        S_LOAD
    } state_t;

    state_t            state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [7:0]        sum_q, sum_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [ADDR_W:0]   cnt_inc;

    assign cnt_inc = cnt_q + (ADDR_W + 1)'(1);

    // NOTE: every _d gets a default before the case so no path leaves it unassigned and infers a latch.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        sum_d      = sum_q;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        done_d     = 1'b0;
        err_d      = 1'b0;

        unique case (state_q)
            S_HOLD: begin
                if (hold_cnt_q == '0) state_d = S_RUN;
                else                  hold_cnt_d = hold_cnt_q - HOLD_W'(1);
            end
            S_RUN: begin
                if (bus.ld_start) begin
                    if (bus.ld_len != '0 && bus.ld_len <= MAX_LEN) begin
                        state_d = S_LOAD;
                        len_d   = bus.ld_len;
                        cnt_d   = '0;
                        sum_d   = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                // Abort wins over a same-cycle handshake: that byte is dropped.
                if (bus.ld_abort) begin
                    err_d      = 1'b1;
                    state_d    = S_HOLD;
                    hold_cnt_d = HOLD_RELOAD;
                end else if (bus.ld_valid) begin
                    we_d    = 1'b1;
                    waddr_d = cnt_q[ADDR_W-1:0];
                    wdata_d = bus.ld_data;
                    cnt_d   = cnt_inc;
                    sum_d   = sum_q + bus.ld_data;
                    if (cnt_inc == len_q) begin
                        state_d    = S_HOLD;
                        hold_cnt_d = HOLD_RELOAD;
                        done_d     = 1'b1;
                    end
                end
            end
            default: begin
                state_d    = S_HOLD;
                hold_cnt_d = HOLD_RELOAD;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_HOLD;
            hold_cnt_q <= HOLD_RELOAD;
            cnt_q      <= '0;
            len_q      <= '0;
            sum_q      <= '0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            sum_q      <= sum_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign bus.ld_ready  = (state_q == S_LOAD);
    assign bus.core_rst  = (state_q != S_RUN);
    assign bus.busy      = (state_q != S_RUN);
    assign bus.mem_we    = we_q;
    assign bus.mem_waddr = waddr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.ld_sum    = sum_q;
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: boot hold, normal loads, rejected starts,
// abort and mid-load reset, with writes captured by a negedge monitor.
module tb_imem_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    imem_loader_if #(.ADDR_W(8)) bus ();

    imem_loader #(.MEM_BYTES(256), .ADDR_W(8), .HOLD_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Write/pulse monitor, sampled mid-cycle.
    int       cyc = 0;
    int       done_cnt = 0;
    int       err_cnt = 0;
    int       wr_addr[$];
    int       wr_data[$];
    int       wr_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.mem_we) begin
                wr_addr.push_back(int'(bus.mem_waddr));
                wr_data.push_back(int'(bus.mem_wdata));
                wr_cyc.push_back(cyc);
            end
            if (bus.done) done_cnt++;
            if (bus.err)  err_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts cycles with core_rst high, starting with the current one.
    task automatic wait_run(output int n);
        n = 0;
        while (bus.core_rst && n < 100) begin
            n++;
            step();
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_core_rst"}, 32'(bus.core_rst), 32'd1);
        check({tag, "_busy"},     32'(bus.busy),     32'd1);
        check({tag, "_ready"},    32'(bus.ld_ready), 32'd0);
        check({tag, "_we"},       32'(bus.mem_we),   32'd0);
        check({tag, "_waddr"},    32'(bus.mem_waddr), 32'd0);
        check({tag, "_wdata"},    32'(bus.mem_wdata), 32'd0);
        check({tag, "_done"},     32'(bus.done),     32'd0);
        check({tag, "_err"},      32'(bus.err),      32'd0);
        check({tag, "_sum"},      32'(bus.ld_sum),   32'd0);
    endtask

    task automatic start_load(input logic [8:0] len);
        bus.ld_start = 1'b1;
        bus.ld_len   = len;
        step();
        bus.ld_start = 1'b0;
    endtask

    initial begin
        int n, hi, base, d0, e0, j;
        logic [7:0] b4 [4];
        logic [7:0] b3 [3];
        logic       vpat [5];

        b4   = '{8'h93, 8'h02, 8'h00, 8'h00};
        b3   = '{8'h11, 8'h22, 8'h33};
        vpat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

        bus.ld_start = 1'b0;
        bus.ld_len   = '0;
        bus.ld_abort = 1'b0;
        bus.ld_valid = 1'b0;
        bus.ld_data  = '0;

        // Reset state, then boot hold with no load.
        step();
        step();
        check_reset_values("rst");
        rst = 1'b0;
        wait_run(n);
        check("boot_hold_cycles", 32'(n), 32'd4);
        check("boot_busy_low", 32'(bus.busy), 32'd0);
        check("boot_no_writes", 32'(wr_addr.size()), 32'd0);

        // Normal 4-byte load with ld_valid held high.
        base = wr_addr.size();
        d0   = done_cnt;
        start_load(9'd4);
        check("load4_ready", 32'(bus.ld_ready), 32'd1);
        hi = 0;
        for (int i = 0; i < 4; i++) begin
            bus.ld_valid = 1'b1;
            bus.ld_data  = b4[i];
            if (bus.core_rst) hi++;
            step();
        end
        bus.ld_valid = 1'b0;
        wait_run(n);
        hi += n;
        check("load4_core_rst_cycles", 32'(hi), 32'd8);
        check("load4_nwrites", 32'(wr_addr.size() - base), 32'd4);
        if (wr_addr.size() - base == 4) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("load4_addr%0d", i), 32'(wr_addr[base+i]), 32'(i));
                check($sformatf("load4_data%0d", i), 32'(wr_data[base+i]), 32'(b4[i]));
            end
            check("load4_consecutive", 32'(wr_cyc[base+3] - wr_cyc[base]), 32'd3);
        end
        check("load4_done", 32'(done_cnt - d0), 32'd1);
        check("load4_sum", 32'(bus.ld_sum), 32'h95);

        // Illegal lengths: 0 and 257.
        base = wr_addr.size();
        start_load(9'd0);
        check("len0_err", 32'(bus.err), 32'd1);
        check("len0_ready", 32'(bus.ld_ready), 32'd0);
        check("len0_busy", 32'(bus.busy), 32'd0);
        step();
        check("len0_err_pulse", 32'(bus.err), 32'd0);
        start_load(9'd257);
        check("len257_err", 32'(bus.err), 32'd1);
        check("len257_ready", 32'(bus.ld_ready), 32'd0);
        step();
        check("len257_err_pulse", 32'(bus.err), 32'd0);
        check("badlen_no_writes", 32'(wr_addr.size() - base), 32'd0);
        check("badlen_sum_kept", 32'(bus.ld_sum), 32'h95);

        // Maximum legal length 256 is accepted; abort at once with no byte.
        e0   = err_cnt;
        base = wr_addr.size();
        start_load(9'd256);
        check("len256_ready", 32'(bus.ld_ready), 32'd1);
        bus.ld_abort = 1'b1;
        step();
        bus.ld_abort = 1'b0;
        check("len256_abort_err", 32'(bus.err), 32'd1);
        wait_run(n);
        check("len256_hold_cycles", 32'(n), 32'd4);
        check("len256_no_writes", 32'(wr_addr.size() - base), 32'd0);

        // 3-byte load with gapped valid and a stray ld_start mid-load.
        base = wr_addr.size();
        d0   = done_cnt;
        start_load(9'd3);
        hi = 0;
        j  = 0;
        for (int i = 0; i < 5; i++) begin
            bus.ld_valid = vpat[i];
            bus.ld_data  = vpat[i] ? b3[j] : 8'hEE;
            bus.ld_start = (i == 1);
            bus.ld_len   = 9'd2;
            if (bus.ld_ready) hi++;
            if (vpat[i]) j++;
            step();
        end
        bus.ld_valid = 1'b0;
        bus.ld_start = 1'b0;
        check("gap_load_cycles", 32'(hi), 32'd5);
        check("gap_ready_after", 32'(bus.ld_ready), 32'd0);
        wait_run(n);
        check("gap_nwrites", 32'(wr_addr.size() - base), 32'd3);
        if (wr_addr.size() - base == 3) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("gap_addr%0d", i), 32'(wr_addr[base+i]), 32'(i));
                check($sformatf("gap_data%0d", i), 32'(wr_data[base+i]), 32'(b3[i]));
            end
        end
        check("gap_done", 32'(done_cnt - d0), 32'd1);
        check("gap_sum", 32'(bus.ld_sum), 32'h66);
        step();
        check("gap_no_restart", 32'(bus.ld_ready), 32'd0);

        // Abort together with the third valid byte of an 8-byte load.
        base = wr_addr.size();
        d0   = done_cnt;
        e0   = err_cnt;
        start_load(9'd8);
        bus.ld_valid = 1'b1;
        bus.ld_data  = 8'hA1;
        step();
        bus.ld_data  = 8'hA2;
        step();
        bus.ld_data  = 8'hA3;
        bus.ld_abort = 1'b1;
        step();
        bus.ld_valid = 1'b0;
        bus.ld_abort = 1'b0;
        check("abort_err", 32'(bus.err), 32'd1);
        check("abort_ready", 32'(bus.ld_ready), 32'd0);
        check("abort_core_rst", 32'(bus.core_rst), 32'd1);
        wait_run(n);
        check("abort_hold_cycles", 32'(n), 32'd4);
        check("abort_nwrites", 32'(wr_addr.size() - base), 32'd2);
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        check("abort_err_count", 32'(err_cnt - e0), 32'd1);
        check("abort_sum", 32'(bus.ld_sum), 32'h43);
        check("abort_busy_low", 32'(bus.busy), 32'd0);

        // Reset in the middle of a load after two bytes.
        start_load(9'd8);
        bus.ld_valid = 1'b1;
        bus.ld_data  = 8'h5A;
        step();
        bus.ld_data  = 8'h3C;
        step();
        bus.ld_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_reset_values("midrst");
        step();
        rst = 1'b0;
        base = wr_addr.size();
        wait_run(n);
        check("midrst_hold_cycles", 32'(n), 32'd4);
        step();
        step();
        check("midrst_not_resumed", 32'(bus.ld_ready), 32'd0);
        check("midrst_no_writes", 32'(wr_addr.size() - base), 32'd0);
        check("midrst_sum", 32'(bus.ld_sum), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end
endmodule
